// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared opcode map, FSM state encoding and flag bundle for
//                the multicycle ALU and its iterative divider.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Opcode map; values 10..15 are treated as illegal by the datapath
    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_MUL = 4'd2,
        OP_DIV = 4'd3,
        OP_MOD = 4'd4,
        OP_SHL = 4'd5,
        OP_SHR = 4'd6,
        OP_AND = 4'd7,
        OP_OR  = 4'd8,
        OP_XOR = 4'd9
    } alu_op_t;

    // Handshake FSM encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DIVIDE = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    // Condition flags, packed in {z,n,c,v} order
    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } alu_flags_t;

endpackage
`default_nettype wire

// File: rtl/alu_divider.sv
`default_nettype none
// ============================================================================
//  Module      : alu_divider
//  Description : Unsigned restoring divider, one quotient bit per cycle.
//                'done' is asserted during the final iteration cycle and
//                quot/rem then carry the values being written that edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_divider #(
    parameter int WIDTH = 4,
    parameter int CNTW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem
);

    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_div;
    logic [CNTW-1:0]  r_cnt;
    logic             r_busy;

    logic [WIDTH:0]   w_rem_sh;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_sub;
    logic [WIDTH-1:0] w_rem_nx;
    logic [WIDTH-1:0] w_quot_nx;
    logic             w_last;

    // One restoring step: shift in next dividend bit, subtract if it fits.
    // The difference is taken modulo 2^WIDTH since a successful subtract
    // always leaves a remainder smaller than the divisor.
    always_comb begin
        w_rem_sh  = {r_rem, r_quot[WIDTH-1]};
        w_ge      = (w_rem_sh >= {1'b0, r_div});
        w_rem_sub = w_rem_sh[WIDTH-1:0] - r_div;
        w_rem_nx  = w_ge ? w_rem_sub : w_rem_sh[WIDTH-1:0];
        w_quot_nx = {r_quot[WIDTH-2:0], w_ge};
    end

    assign w_last = r_busy && (r_cnt == CNTW'(WIDTH - 1));
    assign busy   = r_busy;
    assign done   = w_last;
    assign quot   = w_quot_nx;
    assign rem    = w_rem_nx;

    // Load operands on start, then iterate WIDTH times
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_quot <= '0;
            r_rem  <= '0;
            r_div  <= '0;
        end else if (start && !r_busy) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
            r_quot <= dividend;
            r_rem  <= '0;
            r_div  <= divisor;
        end else if (r_busy) begin
            r_quot <= w_quot_nx;
            r_rem  <= w_rem_nx;
            r_cnt  <= r_cnt + CNTW'(1);
            if (w_last) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_multicycle.sv
`default_nettype none
// ============================================================================
//  Module      : alu_multicycle
//  Description : Registered ALU with valid/ready handshakes. Single-cycle ops
//                resolve at accept; DIV/MOD with a non-zero divisor run the
//                iterative divider for WIDTH cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             z_flag,
    output logic             n_flag,
    output logic             c_flag,
    output logic             v_flag,
    output logic             err
);

    localparam int SHW = $clog2(WIDTH);

    logic [1:0]       r_state;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_result_hi;
    alu_flags_t       r_flags;
    logic             r_err;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH:0]     w_shl;
    logic [WIDTH:0]     w_shr;
    logic [WIDTH-1:0]   w_res;
    logic [WIDTH-1:0]   w_hi;
    logic               w_c;
    logic               w_v;
    logic               w_err;
    alu_flags_t         w_flags;
    logic               w_is_div;
    logic               w_b_zero;
    logic               w_accept;

    logic               w_div_start;
    logic               w_div_busy;
    logic               w_div_done;
    logic [WIDTH-1:0]   w_div_quot;
    logic [WIDTH-1:0]   w_div_rem;
    logic [WIDTH-1:0]   w_div_res;
    alu_flags_t         w_div_flags;

    assign w_accept    = in_valid && (r_state == ST_IDLE);
    assign w_is_div    = (op_code == OP_DIV) || (op_code == OP_MOD);
    assign w_b_zero    = (b == '0);
    assign w_div_start = w_accept && w_is_div && !w_b_zero && !w_div_busy;

    alu_divider #(
        .WIDTH (WIDTH),
        .CNTW  (SHW)
    ) u_divider (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (w_div_start),
        .dividend (a),
        .divisor  (b),
        .busy     (w_div_busy),
        .done     (w_div_done),
        .quot     (w_div_quot),
        .rem      (w_div_rem)
    );

    // Single-cycle datapath; shifts use a guard bit to capture the carry-out
    always_comb begin
        w_sum  = {1'b0, a} + {1'b0, b};
        w_diff = {1'b0, a} - {1'b0, b};
        w_prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        w_shl  = {1'b0, a} << b;
        w_shr  = {a, 1'b0} >> b;
        w_res  = '0;
        w_hi   = '0;
        w_c    = 1'b0;
        w_v    = 1'b0;
        w_err  = 1'b0;
        case (op_code)
            OP_ADD: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                w_res = w_diff[WIDTH-1:0];
                w_c   = w_diff[WIDTH];
                w_v   = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_MUL: begin
                w_res = w_prod[WIDTH-1:0];
                w_hi  = w_prod[2*WIDTH-1:WIDTH];
                w_c   = (w_hi != '0);
                w_v   = (w_hi != '0);
            end
            // Only the divide-by-zero case resolves here
            OP_DIV: begin
                w_res = '1;
                w_err = w_b_zero;
            end
            OP_MOD: begin
                w_res = a;
                w_err = w_b_zero;
            end
            OP_SHL: begin
                w_res = w_shl[WIDTH-1:0];
                w_c   = w_shl[WIDTH];
            end
            OP_SHR: begin
                w_res = w_shr[WIDTH:1];
                w_c   = w_shr[0];
            end
            OP_AND: w_res = a & b;
            OP_OR:  w_res = a | b;
            OP_XOR: w_res = a ^ b;
            default: w_err = 1'b1;
        endcase
        w_flags = '{z: (w_res == '0), n: w_res[WIDTH-1], c: w_c, v: w_v};
    end

    // Divider result selection and its flags
    always_comb begin
        w_div_res   = (r_op == OP_DIV) ? w_div_quot : w_div_rem;
        w_div_flags = '{z: (w_div_res == '0), n: w_div_res[WIDTH-1], c: 1'b0, v: 1'b0};
    end

    // Handshake FSM and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_op        <= '0;
            r_result    <= '0;
            r_result_hi <= '0;
            r_flags     <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_op <= op_code;
                        if (w_is_div && !w_b_zero) begin
                            r_state <= ST_DIVIDE;
                        end else begin
                            r_state     <= ST_DONE;
                            r_result    <= w_res;
                            r_result_hi <= w_hi;
                            r_flags     <= w_flags;
                            r_err       <= w_err;
                        end
                    end
                end
                ST_DIVIDE: begin
                    if (w_div_done) begin
                        r_state     <= ST_DONE;
                        r_result    <= w_div_res;
                        r_result_hi <= '0;
                        r_flags     <= w_div_flags;
                        r_err       <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign result    = r_result;
    assign result_hi = r_result_hi;
    assign z_flag    = r_flags.z;
    assign n_flag    = r_flags.n;
    assign c_flag    = r_flags.c;
    assign v_flag    = r_flags.v;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_multicycle.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_multicycle
//  Description : Directed self-checking bench for alu_multicycle (WIDTH=4)
//                with a queue scoreboard of expected results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_multicycle;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] op_code;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] result;
    logic [3:0] result_hi;
    logic       z_flag;
    logic       n_flag;
    logic       c_flag;
    logic       v_flag;
    logic       err;

    typedef struct packed {
        logic [3:0] res;
        logic [3:0] hi;
        logic [3:0] flags;
        logic       err;
        logic [7:0] lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    alu_multicycle #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op_code   (op_code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .z_flag    (z_flag),
        .n_flag    (n_flag),
        .c_flag    (c_flag),
        .v_flag    (v_flag),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    // Drive one operation, wait for its result, compare against the scoreboard,
    // optionally stall the consumer for 'hold' cycles, then take the result.
    task automatic run_op(input string tag, input logic [3:0] ta, input logic [3:0] tb_v,
                          input logic [3:0] top, input logic [3:0] eres, input logic [3:0] ehi,
                          input logic [3:0] eflags, input logic eerr, input int elat,
                          input int hold);
        exp_t e;
        exp_t got;
        int   lat;
        e.res   = eres;
        e.hi    = ehi;
        e.flags = eflags;
        e.err   = eerr;
        e.lat   = 8'(elat);
        sb.push_back(e);

        @(negedge clk);
        chk({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
        a        = ta;
        b        = tb_v;
        op_code  = top;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        got = sb.pop_front();
        chk({tag, "_latency"}, 32'(lat), 32'(got.lat));
        chk({tag, "_result"}, 32'(result), 32'(got.res));
        chk({tag, "_result_hi"}, 32'(result_hi), 32'(got.hi));
        chk({tag, "_flags_znCV"}, 32'({z_flag, n_flag, c_flag, v_flag}), 32'(got.flags));
        chk({tag, "_err"}, 32'(err), 32'(got.err));
        chk({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_hold_result"}, 32'(result), 32'(got.res));
            chk({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic seen_valid;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        op_code   = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_outputs", 32'({result, result_hi, z_flag, n_flag, c_flag, v_flag, err}), 32'd0);
        rst_n = 1'b1;

        //      tag          a      b      op     res    hi     znCV   err  lat hold
        run_op("add_ff",    4'hF, 4'hF, 4'd0,  4'hE, 4'h0, 4'b0110, 1'b0, 1, 0);
        run_op("sub_0m1",   4'h0, 4'h1, 4'd1,  4'hF, 4'h0, 4'b0110, 1'b0, 1, 0);
        run_op("sub_7mf",   4'h7, 4'hF, 4'd1,  4'h8, 4'h0, 4'b0111, 1'b0, 1, 0);
        run_op("mul_ff",    4'hF, 4'hF, 4'd2,  4'h1, 4'hE, 4'b0011, 1'b0, 1, 0);
        run_op("mul_22",    4'h2, 4'h2, 4'd2,  4'h4, 4'h0, 4'b0000, 1'b0, 1, 0);
        run_op("div_4_2",   4'h4, 4'h2, 4'd3,  4'h2, 4'h0, 4'b0000, 1'b0, 5, 0);
        run_op("mod_7_3",   4'h7, 4'h3, 4'd4,  4'h1, 4'h0, 4'b0000, 1'b0, 5, 0);
        run_op("div_f_2",   4'hF, 4'h2, 4'd3,  4'h7, 4'h0, 4'b0000, 1'b0, 5, 0);
        run_op("mod_d_4",   4'hD, 4'h4, 4'd4,  4'h1, 4'h0, 4'b0000, 1'b0, 5, 0);
        run_op("div_by_0",  4'h2, 4'h0, 4'd3,  4'hF, 4'h0, 4'b0100, 1'b1, 1, 0);
        run_op("mod_by_0",  4'h5, 4'h0, 4'd4,  4'h5, 4'h0, 4'b0000, 1'b1, 1, 0);
        run_op("shl_a_1",   4'hA, 4'h1, 4'd5,  4'h4, 4'h0, 4'b0010, 1'b0, 1, 0);
        run_op("shr_5_1",   4'h5, 4'h1, 4'd6,  4'h2, 4'h0, 4'b0010, 1'b0, 1, 0);
        run_op("shl_a_4",   4'hA, 4'h4, 4'd5,  4'h0, 4'h0, 4'b1000, 1'b0, 1, 0);
        run_op("shr_8_5",   4'h8, 4'h5, 4'd6,  4'h0, 4'h0, 4'b1000, 1'b0, 1, 0);
        run_op("shl_3_0",   4'h3, 4'h0, 4'd5,  4'h3, 4'h0, 4'b0000, 1'b0, 1, 0);
        run_op("illegal_f", 4'h6, 4'h3, 4'd15, 4'h0, 4'h0, 4'b1000, 1'b1, 1, 0);
        run_op("or_5_2",    4'h5, 4'h2, 4'd8,  4'h7, 4'h0, 4'b0000, 1'b0, 1, 0);
        run_op("xor_a_a",   4'hA, 4'hA, 4'd9,  4'h0, 4'h0, 4'b1000, 1'b0, 1, 0);
        run_op("hold_add",  4'h3, 4'h1, 4'd0,  4'h4, 4'h0, 4'b0000, 1'b0, 1, 3);
        run_op("and_c_a",   4'hC, 4'hA, 4'd7,  4'h8, 4'h0, 4'b0100, 1'b0, 1, 0);

        // Reset in the middle of a divide: outputs clear, no stale result appears
        @(negedge clk);
        a        = 4'h7;
        b        = 4'h2;
        op_code  = 4'd3;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("middiv_busy", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("middiv_rst_in_ready", 32'(in_ready), 32'd1);
        chk("middiv_rst_out_valid", 32'(out_valid), 32'd0);
        chk("middiv_rst_outputs", 32'({result, result_hi, z_flag, n_flag, c_flag, v_flag, err}), 32'd0);
        rst_n      = 1'b1;
        seen_valid = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen_valid = seen_valid | out_valid;
        end
        chk("middiv_no_stale_valid", 32'(seen_valid), 32'd0);

        run_op("div_7_2",   4'h7, 4'h2, 4'd3,  4'h3, 4'h0, 4'b0000, 1'b0, 5, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
